// File: rtl/lsc_pkg.sv
// Shared opcodes, FSM state type and DMA header packing for the multi-channel load/store controller.
package lsc_pkg;

  localparam logic [7:0]  OP_READ   = 8'h01;
  localparam logic [7:0]  OP_WRITE  = 8'h03;

  localparam int unsigned TAG_W     = 8;
  localparam int unsigned OP_W      = 8;
  localparam int unsigned PAD_W     = 4;
  localparam int unsigned HDR_MAX_W = 256;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_WDATA,
    ST_DONE
  } lsc_state_e;

  // Header layout, LSB first: local, 4-bit pad, host, len, opcode, tag, zero pad.
  function automatic logic [HDR_MAX_W-1:0] hdr_pack(
    input logic [TAG_W-1:0] tag,
    input logic [OP_W-1:0]  op,
    input logic [63:0]      len,
    input logic [63:0]      host,
    input logic [63:0]      lcl,
    input int unsigned      len_w,
    input int unsigned      host_aw,
    input int unsigned      local_aw
  );
    int unsigned host_lsb;
    int unsigned len_lsb;
    int unsigned op_lsb;
    int unsigned tag_lsb;
    host_lsb = local_aw + PAD_W;
    len_lsb  = host_lsb + host_aw;
    op_lsb   = len_lsb + len_w;
    tag_lsb  = op_lsb + OP_W;
    return HDR_MAX_W'(lcl)
         | (HDR_MAX_W'(host) << host_lsb)
         | (HDR_MAX_W'(len)  << len_lsb)
         | (HDR_MAX_W'(op)   << op_lsb)
         | (HDR_MAX_W'(tag)  << tag_lsb);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from ptr_i+1 upward (wrapping) and returns the first requester.
module rr_arbiter #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned IDX_W  = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [IDX_W-1:0]  ptr_i,
  output logic [NUM_CH-1:0] grant_o,
  output logic [IDX_W-1:0]  grant_idx_o,
  output logic              any_o
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    cand        = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = IDX_W'((32'(ptr_i) + i) % NUM_CH);
      if (!any_o && req_i[cand]) begin
        any_o         = 1'b1;
        grant_idx_o   = cand;
        grant_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_ls_controller.sv
// Multi-channel load/store controller: round-robin core arbitration onto one DMA path, tagged read return.
// Optional per-channel accepted write-beat counters when LSC_BEAT_CNT_EN is defined.
module multi_ls_controller
  import lsc_pkg::*;
#(
  parameter int unsigned NUM_CH   = 2,
  parameter int unsigned DATA_W   = 128,
  parameter int unsigned HOST_AW  = 40,
  parameter int unsigned LOCAL_AW = 12,
  parameter int unsigned LEN_W    = 16,
  parameter int unsigned CH_W     = 3
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_CH-1:0]               core_req,
  output logic [NUM_CH-1:0]               core_ready,
  input  logic [NUM_CH-1:0]               core_rwn,
  input  logic [NUM_CH*HOST_AW-1:0]       core_hostAddr,
  input  logic [NUM_CH*LOCAL_AW-1:0]      core_localAddr,
  input  logic [NUM_CH*LEN_W-1:0]         core_transferLength,
  input  logic [NUM_CH*DATA_W-1:0]        core_writeData,
  output logic [NUM_CH-1:0]               core_ack,
  output logic [DATA_W-1:0]               core_readData,
  output logic [LOCAL_AW-1:0]             core_readAddr,
  output logic [NUM_CH-1:0]               core_done,
  output logic                            dma_req,
  input  logic                            dma_resp,
  output logic                            dma_write_valid,
  output logic [DATA_W-1:0]               dma_write_data,
  input  logic                            dma_write_ready,
  input  logic                            dma_read_valid,
  input  logic [DATA_W+LOCAL_AW+CH_W-1:0] dma_read_data,
  output logic                            dma_read_ready,
  output logic [NUM_CH*32-1:0]            ch_beat_cnt
);

  localparam int unsigned IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [HOST_AW-1:0]  host_a  [NUM_CH];
  logic [LOCAL_AW-1:0] local_a [NUM_CH];
  logic [LEN_W-1:0]    len_a   [NUM_CH];
  logic [DATA_W-1:0]   wdata_a [NUM_CH];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
    assign host_a[i]  = core_hostAddr[i*HOST_AW +: HOST_AW];
    assign local_a[i] = core_localAddr[i*LOCAL_AW +: LOCAL_AW];
    assign len_a[i]   = core_transferLength[i*LEN_W +: LEN_W];
    assign wdata_a[i] = core_writeData[i*DATA_W +: DATA_W];
  end

  lsc_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic                rwn_q, rwn_d;
  logic [HOST_AW-1:0]  host_q, host_d;
  logic [LOCAL_AW-1:0] local_q, local_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    cnt_q, cnt_d;
  logic                dma_req_q, dma_req_d;
  logic [NUM_CH-1:0]   ready_q, ready_d;

  logic [NUM_CH-1:0]   arb_grant;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_any;
  logic [DATA_W-1:0]   hdr_beat;
  logic [NUM_CH-1:0]   wr_ack, rd_ack, done_c;
  logic                wr_valid;
  logic [DATA_W-1:0]   wr_data;

  rr_arbiter #(.NUM_CH(NUM_CH), .IDX_W(IDX_W)) u_arb (
    .req_i       (core_req),
    .ptr_i       (ptr_q),
    .grant_o     (arb_grant),
    .grant_idx_o (arb_idx),
    .any_o       (arb_any)
  );

  assign hdr_beat = DATA_W'(hdr_pack(8'(grant_q), rwn_q ? OP_READ : OP_WRITE, 64'(len_q),
                                     64'(host_q), 64'(local_q), LEN_W, HOST_AW, LOCAL_AW));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      ptr_q     <= '0;
      rwn_q     <= 1'b0;
      host_q    <= '0;
      local_q   <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      dma_req_q <= 1'b0;
      ready_q   <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      ptr_q     <= ptr_d;
      rwn_q     <= rwn_d;
      host_q    <= host_d;
      local_q   <= local_d;
      len_q     <= len_d;
      cnt_q     <= cnt_d;
      dma_req_q <= dma_req_d;
      ready_q   <= ready_d;
    end
  end

  // Next-state and beat-path logic; write beats are offered exactly when the DMA can take them.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    rwn_d     = rwn_q;
    host_d    = host_q;
    local_d   = local_q;
    len_d     = len_q;
    cnt_d     = cnt_q;
    dma_req_d = dma_req_q;
    ready_d   = ready_q;
    wr_valid  = 1'b0;
    wr_data   = '0;
    wr_ack    = '0;
    done_c    = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (arb_any && (arb_grant != '0)) begin
          grant_d   = arb_idx;
          rwn_d     = core_rwn[arb_idx];
          host_d    = host_a[arb_idx];
          local_d   = local_a[arb_idx];
          len_d     = len_a[arb_idx];
          dma_req_d = 1'b1;
          state_d   = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dma_resp) begin
          dma_req_d        = 1'b0;
          ready_d          = '0;
          ready_d[grant_q] = 1'b1;
          state_d          = ST_HDR;
        end
      end
      ST_HDR: begin
        wr_valid = dma_write_ready;
        wr_data  = hdr_beat;
        if (dma_write_ready) begin
          cnt_d   = '0;
          state_d = (rwn_q || (len_q == '0)) ? ST_DONE : ST_WDATA;
        end
      end
      ST_WDATA: begin
        wr_valid = dma_write_ready;
        wr_data  = wdata_a[grant_q];
        if (dma_write_ready) begin
          wr_ack[grant_q] = 1'b1;
          cnt_d           = cnt_q + 1'b1;
          if (cnt_q == len_q - 1'b1) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        ready_d         = '0;
        done_c[grant_q] = 1'b1;
        ptr_d           = grant_q;
        state_d         = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Read return is routed purely by the bus tag, independent of the transfer FSM.
  logic [CH_W-1:0] rd_tag;
  logic            rd_hit;

  assign rd_tag = dma_read_data[DATA_W+LOCAL_AW +: CH_W];
  assign rd_hit = dma_read_valid && !rst && (32'(rd_tag) < NUM_CH);

  always_comb begin
    rd_ack = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      rd_ack[i] = rd_hit && (32'(rd_tag) == i);
    end
  end

  assign core_ack        = wr_ack | rd_ack;
  assign core_readData   = rd_hit ? dma_read_data[DATA_W-1:0] : '0;
  assign core_readAddr   = rd_hit ? dma_read_data[DATA_W +: LOCAL_AW] : '0;
  assign core_done       = done_c;
  assign core_ready      = ready_q;
  assign dma_req         = dma_req_q;
  assign dma_write_valid = wr_valid;
  assign dma_write_data  = wr_data;
  assign dma_read_ready  = !rst;

`ifdef LSC_BEAT_CNT_EN
  logic [31:0] beat_cnt_q [NUM_CH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) beat_cnt_q[i] <= '0;
    end else if ((state_q == ST_WDATA) && dma_write_ready) begin
      beat_cnt_q[grant_q] <= beat_cnt_q[grant_q] + 32'd1;
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_cnt
    assign ch_beat_cnt[i*32 +: 32] = beat_cnt_q[i];
  end
`else
  assign ch_beat_cnt = '0;
`endif

endmodule
